aes_block_loader: RTL

//  Upstream feeder for the combinational AES-128 cipher datapath.
//  - Packs a word stream (valid/ready) into 128-bit key and plaintext blocks.
//  - Holds the key across any number of plaintext blocks.
//  - Drives plaintext/key stable on registers with a blk_valid/blk_ready handshake.
//  - Assembles the next block while the current one is held.

---
 rtl/aes_pkg.sv | 42 ++++
 rtl/aes_block_loader_if.sv | 39 +++
 rtl/aes_word_packer.sv | 87 ++++++++
 rtl/aes_block_loader.sv | 133 +++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_pkg
// Description : Shared AES-128 constants and types (block width, round
//               constants, block/word typedefs) used by the cipher and its
//               block loader.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

  localparam int AES_BLK_W  = 128;
  localparam int AES_WORD_W = 32;

  // Key-schedule round constants (rcon[i] = x^(i-1) in GF(2^8))
  localparam logic [7:0] AES_RCON1  = 8'h01;
  localparam logic [7:0] AES_RCON2  = 8'h02;
  localparam logic [7:0] AES_RCON3  = 8'h04;
  localparam logic [7:0] AES_RCON4  = 8'h08;
  localparam logic [7:0] AES_RCON5  = 8'h10;
  localparam logic [7:0] AES_RCON6  = 8'h20;
  localparam logic [7:0] AES_RCON7  = 8'h40;
  localparam logic [7:0] AES_RCON8  = 8'h80;
  localparam logic [7:0] AES_RCON9  = 8'h1b;
  localparam logic [7:0] AES_RCON10 = 8'h36;

  // Bit 0 is the most significant bit of the block (FIPS-197 byte order)
  typedef logic [0:AES_BLK_W-1]  aes_blk_t;
  typedef logic [0:AES_WORD_W-1] aes_word_t;

  // Type of the block currently being assembled
  typedef enum logic {
    BLK_PT  = 1'b0,
    BLK_KEY = 1'b1
  } blk_type_e;

  // Number of input words making up one block
  function automatic int words_per_blk(input int word_w);
    return AES_BLK_W / word_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_block_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : aes_block_loader_if
// Description : Word-stream input and block-output handshake bundle of the
//               AES block loader. The loader sits on the slave modport; the
//               word source / cipher side sits on the master modport.
// Revision    : 1.0 - initial release
// ============================================================================
interface aes_block_loader_if #(
  parameter int WORD_W = 32
);
  import aes_pkg::*;

  // word stream
  logic              s_valid;
  logic              s_ready;
  logic [0:WORD_W-1] s_data;
  logic              s_is_key;
  logic              clear_key;
  // block output
  aes_blk_t          plaintext;
  aes_blk_t          key;
  logic              blk_valid;
  logic              blk_ready;
  logic              key_valid;
  logic              err;

  modport slave (
    input  s_valid, s_data, s_is_key, clear_key, blk_ready,
    output s_ready, plaintext, key, blk_valid, key_valid, err
  );

  modport master (
    output s_valid, s_data, s_is_key, clear_key, blk_ready,
    input  s_ready, plaintext, key, blk_valid, key_valid, err
  );

endinterface
`default_nettype wire

// File: rtl/aes_word_packer.sv
`default_nettype none
// ============================================================================
// Module      : aes_word_packer
// Description : Shifts accepted words into a 128-bit assembly buffer, counts
//               words, latches the block type from word 0 and detects type
//               mismatches. Raises a combinational one-cycle done flag with
//               the completed block so the caller can register it on the
//               same edge as the last word.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_word_packer
  import aes_pkg::*;
#(
  parameter int WORD_W = 32   // 8, 16, 32 or 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              accept_i,     // word transferred this edge
  input  logic              flush_key_i,  // discard a partial key block
  input  logic [0:WORD_W-1] data_i,
  input  logic              is_key_i,
  output logic              last_slot_o,  // next accepted word completes a block
  output logic              done_o,
  output logic              mismatch_o,
  output blk_type_e         type_o,
  output aes_blk_t          blk_o
);

  localparam int WORDS = words_per_blk(WORD_W);
  localparam int CNT_W = $clog2(WORDS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORDS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_eff;
  blk_type_e        type_q, type_d, word_type;
  aes_blk_t         buf_q, buf_d;

  assign word_type = blk_type_e'(is_key_i);

  // Word count, type latch, shift buffer and completion/mismatch decode
  always_comb begin
    // A flushed partial key restarts counting before this edge's word
    cnt_eff    = (flush_key_i && type_q == BLK_KEY) ? '0 : cnt_q;
    cnt_d      = cnt_eff;
    type_d     = type_q;
    buf_d      = buf_q;
    done_o     = 1'b0;
    mismatch_o = 1'b0;
    if (accept_i) begin
      // Earlier words move toward bit 0; stale words fall off after WORDS shifts
      buf_d = {buf_q[WORD_W +: AES_BLK_W-WORD_W], data_i};
      if (cnt_eff == '0) begin
        type_d = word_type;
        cnt_d  = CNT_ONE;
      end else if (word_type != type_q) begin
        // The offending word starts a fresh block of its own type
        mismatch_o = 1'b1;
        type_d     = word_type;
        cnt_d      = CNT_ONE;
      end else if (cnt_eff == CNT_LAST) begin
        done_o = 1'b1;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_eff + CNT_ONE;
      end
    end
  end

  // Assembly state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      type_q <= BLK_PT;
      buf_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      type_q <= type_d;
      buf_q  <= buf_d;
    end
  end

  assign last_slot_o = (cnt_q == CNT_LAST);
  assign type_o      = type_q;
  assign blk_o       = buf_d;

endmodule
`default_nettype wire

// File: rtl/aes_block_loader.sv
`default_nettype none
// ============================================================================
// Module      : aes_block_loader
// Description : Upstream feeder for the combinational AES-128 datapath.
//               Packs a valid/ready word stream into key and plaintext
//               blocks, holds the key across many plaintext blocks and
//               presents registered plaintext/key with a blk_valid/blk_ready
//               handshake while the next block is being assembled.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_block_loader
  import aes_pkg::*;
#(
  parameter int WORD_W = 32   // 8, 16, 32 or 64
) (
  input  logic                clk,
  input  logic                rst_n,
  aes_block_loader_if.slave   bus
);

  aes_blk_t  pt_q, pt_d;
  aes_blk_t  key_q, key_d;
  logic      blk_valid_q, blk_valid_d;
  logic      key_valid_q, key_valid_d;
  logic      clr_pend_q, clr_pend_d;
  logic      err_q, err_d;

  logic      s_ready;
  logic      accept;
  logic      drop_key_word;
  logic      pk_last_slot;
  logic      pk_done;
  logic      pk_mismatch;
  blk_type_e pk_type;
  aes_blk_t  pk_blk;

  // The last word of a block may only land when the held pair can be replaced
  assign s_ready       = !(pk_last_slot && blk_valid_q && !bus.blk_ready);
  assign accept        = bus.s_valid && s_ready;
  // A key word arriving with clear_key is discarded: the clear wins
  assign drop_key_word = bus.clear_key && bus.s_is_key;

  aes_word_packer #(
    .WORD_W (WORD_W)
  ) u_packer (
    .clk         (clk),
    .rst_n       (rst_n),
    .accept_i    (accept && !drop_key_word),
    .flush_key_i (bus.clear_key),
    .data_i      (bus.s_data),
    .is_key_i    (bus.s_is_key),
    .last_slot_o (pk_last_slot),
    .done_o      (pk_done),
    .mismatch_o  (pk_mismatch),
    .type_o      (pk_type),
    .blk_o       (pk_blk)
  );

  // Output block, key ownership and error pulse next-state
  always_comb begin
    pt_d        = pt_q;
    key_d       = key_q;
    blk_valid_d = blk_valid_q;
    key_valid_d = key_valid_q;
    clr_pend_d  = clr_pend_q;
    err_d       = pk_mismatch;

    if (blk_valid_q && bus.blk_ready) begin
      blk_valid_d = 1'b0;
    end

    // Plaintext needs a key that is still valid after this edge
    if (pk_done && pk_type == BLK_PT) begin
      if (key_valid_q && !bus.clear_key) begin
        pt_d        = pk_blk;
        blk_valid_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end

    // Deferred zeroing once the cipher has released the held pair
    if (clr_pend_q && !blk_valid_q) begin
      key_d      = '0;
      clr_pend_d = 1'b0;
    end

    if (bus.clear_key) begin
      key_valid_d = 1'b0;
      if (!blk_valid_q) begin
        key_d      = '0;
        clr_pend_d = 1'b0;
      end else begin
        clr_pend_d = 1'b1;
      end
    end

    // A fresh key supersedes any pending clear
    if (pk_done && pk_type == BLK_KEY) begin
      key_d       = pk_blk;
      key_valid_d = 1'b1;
      clr_pend_d  = 1'b0;
    end
  end

  // Output and control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pt_q        <= '0;
      key_q       <= '0;
      blk_valid_q <= 1'b0;
      key_valid_q <= 1'b0;
      clr_pend_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      pt_q        <= pt_d;
      key_q       <= key_d;
      blk_valid_q <= blk_valid_d;
      key_valid_q <= key_valid_d;
      clr_pend_q  <= clr_pend_d;
      err_q       <= err_d;
    end
  end

  assign bus.s_ready   = s_ready;
  assign bus.plaintext = pt_q;
  assign bus.key       = key_q;
  assign bus.blk_valid = blk_valid_q;
  assign bus.key_valid = key_valid_q;
  assign bus.err       = err_q;

endmodule
`default_nettype wire
